// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
interface icache_dm_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hitcnt;
  logic [31:0] misscnt;

  // Cache side
  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr, hitcnt, misscnt
  );

  // Fetch stage / memory controller / environment side
  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hitcnt, misscnt
  );
endinterface

// File: rtl/icache_dm.sv
// 16-frame direct-mapped instruction cache, one word per frame, zero-cycle hit,
// blocking single-word refill from the memory controller.
module icache_dm (
  input  logic        CLK,
  input  logic        nRST,
  icache_dm_if.slave  bus
);
  localparam int unsigned FRAMES = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned TAG_W  = 26;
  localparam int unsigned WORD_W = 32;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [FRAMES-1:0]   valid_q;
  logic [TAG_W-1:0]    tag_q  [FRAMES];
  logic [WORD_W-1:0]   data_q [FRAMES];
  logic [WORD_W-1:0]   missaddr_q;
  logic [WORD_W-1:0]   hitcnt_q;
  logic [WORD_W-1:0]   misscnt_q;
  logic                iren_q;

  logic [IDX_W-1:0]    req_idx, fill_idx;
  logic [TAG_W-1:0]    req_tag, fill_tag;
  logic                hit_c, miss_c, fill_c;
  logic                unused_addr_lsb;

  assign req_idx         = bus.imemaddr[5:2];
  assign req_tag         = bus.imemaddr[31:6];
  assign fill_idx        = missaddr_q[5:2];
  assign fill_tag        = missaddr_q[31:6];
  assign unused_addr_lsb = ^bus.imemaddr[1:0];

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle hit/miss/fill decode
  always_comb begin
    state_d = state_q;
    hit_c   = 1'b0;
    miss_c  = 1'b0;
    fill_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.imemREN) begin
          if (valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
            hit_c = 1'b1;
          end else begin
            miss_c  = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (!bus.iwait) begin
          fill_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Miss address doubles as iaddr: loaded on a miss, zeroed once the fill lands
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q    <= '0;
      missaddr_q <= '0;
      iren_q     <= 1'b0;
      hitcnt_q   <= '0;
      misscnt_q  <= '0;
    end else begin
      if (hit_c) hitcnt_q <= hitcnt_q + 32'd1;
      if (miss_c) begin
        missaddr_q <= bus.imemaddr;
        iren_q     <= 1'b1;
        misscnt_q  <= misscnt_q + 32'd1;
      end
      if (fill_c) begin
        valid_q[fill_idx] <= 1'b1;
        missaddr_q        <= '0;
        iren_q            <= 1'b0;
      end
    end
  end

  // Frame tag/data store; contents are meaningless until the valid bit is set
  always_ff @(posedge CLK) begin
    if (fill_c) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.iload;
    end
  end

  assign bus.ihit     = hit_c;
  assign bus.imemload = hit_c ? data_q[req_idx] : '0;
  assign bus.iREN     = iren_q;
  assign bus.iaddr    = missaddr_q;
  assign bus.hitcnt   = hitcnt_q;
  assign bus.misscnt  = misscnt_q;
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, repeat hits, conflict eviction,
// address change mid-fill, reset mid-fill and hit counter wrap.
module tb_icache_dm;
  logic CLK;
  logic nRST;
  int   n_cmp;
  int   n_err;

  icache_dm_if bus ();

  icache_dm dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Request addr in IDLE (must miss), then serve it after `waits` busy cycles.
  // Returns at the negedge of the first IDLE cycle with the request still held.
  task automatic fill(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input int waits);
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    bus.iwait    = 1'b1;
    #1 chk({tag, "_miss_ihit"}, 32'(bus.ihit), 32'd0);
    chk({tag, "_miss_iren"}, 32'(bus.iREN), 32'd0);
    @(negedge CLK);
    for (int i = 0; i <= waits; i++) begin
      bus.iwait = (i < waits);
      bus.iload = (i < waits) ? 32'hDEAD_BEEF : d;
      #1 chk({tag, "_fetch_iren"}, 32'(bus.iREN), 32'd1);
      chk({tag, "_fetch_iaddr"}, bus.iaddr, a);
      chk({tag, "_fetch_ihit"}, 32'(bus.ihit), 32'd0);
      @(negedge CLK);
    end
    bus.iwait = 1'b1;
    bus.iload = 32'h0;
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    nRST         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0;
    bus.iwait    = 1'b1;
    bus.iload    = 32'h0;

    // Reset state
    repeat (2) @(negedge CLK);
    #1 chk("rst_ihit", 32'(bus.ihit), 32'd0);
    chk("rst_iren", 32'(bus.iREN), 32'd0);
    chk("rst_iaddr", bus.iaddr, 32'h0);
    chk("rst_hitcnt", bus.hitcnt, 32'h0);
    chk("rst_misscnt", bus.misscnt, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // Cold miss with three busy cycles, then the retried access hits
    fill("cold", 32'h0000_0040, 32'h8C22_0004, 3);
    #1 chk("cold_hit", 32'(bus.ihit), 32'd1);
    chk("cold_load", bus.imemload, 32'h8C22_0004);
    chk("cold_misscnt", bus.misscnt, 32'd1);
    chk("cold_hitcnt_before", bus.hitcnt, 32'd0);
    @(negedge CLK);
    #1 chk("cold_hitcnt", bus.hitcnt, 32'd1);

    // Held request keeps hitting, one count per cycle
    for (int i = 0; i < 5; i++) begin
      chk("rep_ihit", 32'(bus.ihit), 32'd1);
      chk("rep_iren", 32'(bus.iREN), 32'd0);
      @(negedge CLK);
      #1;
    end
    chk("rep_hitcnt", bus.hitcnt, 32'd6);

    // Idle request: no output, no counter movement
    bus.imemREN = 1'b0;
    #1 chk("idle_ihit", 32'(bus.ihit), 32'd0);
    chk("idle_load", bus.imemload, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    #1 chk("idle_hitcnt", bus.hitcnt, 32'd6);
    chk("idle_misscnt", bus.misscnt, 32'd1);
    @(negedge CLK);

    // Conflict: 0x80 evicts 0x40 from frame 0, then 0x40 misses again
    fill("conf80", 32'h0000_0080, 32'h1111_1111, 1);
    #1 chk("conf80_hit", 32'(bus.ihit), 32'd1);
    chk("conf80_load", bus.imemload, 32'h1111_1111);
    fill("conf40", 32'h0000_0040, 32'h8C22_0004, 0);
    #1 chk("conf40_hit", 32'(bus.ihit), 32'd1);
    chk("conf40_load", bus.imemload, 32'h8C22_0004);
    chk("conf_misscnt", bus.misscnt, 32'd3);
    chk("conf_hitcnt", bus.hitcnt, 32'd6);
    bus.imemREN = 1'b0;
    @(negedge CLK);

    // Address change and request drop mid-fill: fill still targets 0x44
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0044;
    #1 chk("chg_miss", 32'(bus.ihit), 32'd0);
    @(negedge CLK);
    bus.imemaddr = 32'h0000_0048;
    bus.imemREN  = 1'b0;
    #1 chk("chg_iaddr_busy", bus.iaddr, 32'h0000_0044);
    chk("chg_iren_busy", 32'(bus.iREN), 32'd1);
    @(negedge CLK);
    bus.iwait = 1'b0;
    bus.iload = 32'h2222_2222;
    #1 chk("chg_iaddr_done", bus.iaddr, 32'h0000_0044);
    @(negedge CLK);
    bus.iwait    = 1'b1;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0044;
    #1 chk("chg_44_hit", 32'(bus.ihit), 32'd1);
    chk("chg_44_load", bus.imemload, 32'h2222_2222);
    chk("chg_iren_idle", 32'(bus.iREN), 32'd0);
    chk("chg_iaddr_idle", bus.iaddr, 32'h0);
    bus.imemaddr = 32'h0000_0048;
    #1 chk("chg_48_miss", 32'(bus.ihit), 32'd0);
    @(negedge CLK);
    bus.imemREN = 1'b0;
    bus.iwait   = 1'b0;
    bus.iload   = 32'h3333_3333;
    #1 chk("chg_48_iaddr", bus.iaddr, 32'h0000_0048);
    chk("chg_misscnt", bus.misscnt, 32'd5);
    @(negedge CLK);
    bus.iwait = 1'b1;

    // Reset during FETCH drops iREN at once and discards cached contents
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_008C;
    @(negedge CLK);
    bus.imemREN = 1'b0;
    #1 chk("rf_iren_before", 32'(bus.iREN), 32'd1);
    #2 nRST = 1'b0;
    #1 chk("rf_iren_async", 32'(bus.iREN), 32'd0);
    chk("rf_iaddr_async", bus.iaddr, 32'h0);
    chk("rf_hitcnt", bus.hitcnt, 32'h0);
    chk("rf_misscnt", bus.misscnt, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    fill("rf40", 32'h0000_0040, 32'hAAAA_5555, 0);
    #1 chk("rf40_hit", 32'(bus.ihit), 32'd1);
    chk("rf40_load", bus.imemload, 32'hAAAA_5555);
    chk("rf40_misscnt", bus.misscnt, 32'd1);
    bus.imemREN = 1'b0;

    // Hit counter wrap
    force dut.hitcnt_q = 32'hFFFF_FFFF;
    @(negedge CLK);
    release dut.hitcnt_q;
    #1 chk("wrap_preset", bus.hitcnt, 32'hFFFF_FFFF);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0040;
    #1 chk("wrap_ihit", 32'(bus.ihit), 32'd1);
    @(negedge CLK);
    bus.imemREN = 1'b0;
    #1 chk("wrap_hitcnt", bus.hitcnt, 32'h0);
    chk("wrap_misscnt", bus.misscnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
